// File: rtl/sam_mem_ctrl.sv
// rtl/sam_mem_ctrl.sv - sample RAM sequencer: single-word writes and backpressured read bursts
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_last  decoded command handshake (in_last unused)
//   cmd_wr_en, cmd_rd_en       command type flags (cmd_go unused)
//   cmd_wr_addr, cmd_wr_data   write address / data
//   cmd_rd_start, cmd_rd_end   inclusive read burst bounds (wrap through 0)
//   ram_addr/ram_din/ram_en/ram_wen/ram_dout   single-port RAM, 1-cycle read latency
//   out_data/out_valid/out_ready/out_last      output stream, zero-extended words
module sam_mem_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              cmd_wr_en,
    input  logic              cmd_rd_en,
    input  logic              cmd_go,
    input  logic [ADDR_W-1:0] cmd_wr_addr,
    input  logic [DATA_W-1:0] cmd_wr_data,
    input  logic [ADDR_W-1:0] cmd_rd_start,
    input  logic [ADDR_W-1:0] cmd_rd_end,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_en,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] rd_end;
    logic              pend, pend_last;
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W:0]   head;
    logic              accept, room, issue, issue_last, push, pop;
    logic              unused_ok;

    assign unused_ok = ^{in_last, cmd_go};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;

    // A read may only be issued if its word is guaranteed a FIFO slot,
    // counting the word still in flight from last cycle's issue.
    assign room = (32'(count) + 32'(pend)) < 32'(FIFO_DEPTH);

    assign head      = fifo_mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? OUT_W'(head[DATA_W-1:0]) : '0;
    assign out_last  = out_valid & head[DATA_W];
    assign pop       = out_valid && out_ready;
    assign push      = pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ram_en     = 1'b0;
        ram_wen    = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_rd_en)      state_nx = S_READ;
                    else if (cmd_wr_en) state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_en   = 1'b1;
                ram_wen  = 1'b1;
                state_nx = S_IDLE;
            end
            S_READ: begin
                if (room) begin
                    issue      = 1'b1;
                    ram_en     = 1'b1;
                    issue_last = (ram_addr == rd_end);
                    if (issue_last) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave on the edge that pops the final word so in_ready
                // rises in the very next cycle.
                if (!pend && (count == '0 || (count == CNT_W'(1) && pop)))
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ram_addr doubles as the burst address counter; it stops on the end
    // address so it holds the last strobed value after the burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_addr  <= '0;
            ram_din   <= '0;
            rd_end    <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (accept && cmd_rd_en) begin
                ram_addr <= cmd_rd_start;
                rd_end   <= cmd_rd_end;
            end else if (accept && cmd_wr_en) begin
                ram_addr <= cmd_wr_addr;
                ram_din  <= cmd_wr_data;
            end else if (issue && !issue_last) begin
                ram_addr <= ram_addr + 1'b1;
            end
            pend      <= issue;
            pend_last <= issue_last;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pend_last, ram_dout};
    end

endmodule

// File: tb/tb_sam_mem_ctrl.sv
// tb/tb_sam_mem_ctrl.sv - directed self-checking bench for sam_mem_ctrl
module tb_sam_mem_ctrl;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int OUT_W  = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0, in_last = 1'b0, cmd_go = 1'b0;
    logic              cmd_wr_en = 1'b0, cmd_rd_en = 1'b0;
    logic [ADDR_W-1:0] cmd_wr_addr = '0, cmd_rd_start = '0, cmd_rd_end = '0;
    logic [DATA_W-1:0] cmd_wr_data = '0;
    logic              in_ready, ram_en, ram_wen, out_valid, out_last;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout = '0;
    logic [OUT_W-1:0]  out_data;

    sam_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .cmd_wr_en(cmd_wr_en), .cmd_rd_en(cmd_rd_en), .cmd_go(cmd_go),
        .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
        .cmd_rd_start(cmd_rd_start), .cmd_rd_end(cmd_rd_end),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_en(ram_en), .ram_wen(ram_wen),
        .ram_dout(ram_dout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    bit [DATA_W-1:0] mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) mem[ram_addr] <= ram_din;
            else         ram_dout <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [OUT_W-1:0] q_data[$];
    logic             q_last[$];
    int iss = 0, pops = 0, max_out = 0, wen_cnt = 0, en_cnt = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            iss  = 0;
            pops = 0;
        end else begin
            if (ram_en) en_cnt++;
            if (ram_en && ram_wen) wen_cnt++;
            if (ram_en && !ram_wen) begin
                iss++;
                if (iss - pops > max_out) max_out = iss - pops;
            end
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                pops++;
            end
        end
    end

    int tests = 0, fails = 0;
    int c0 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic rd, input logic wr, input logic [ADDR_W-1:0] wa,
                            input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] rs,
                            input logic [ADDR_W-1:0] re);
        in_valid = 1'b1; cmd_rd_en = rd; cmd_wr_en = wr;
        cmd_wr_addr = wa; cmd_wr_data = wd; cmd_rd_start = rs; cmd_rd_end = re;
        @(posedge clk); #2;
        in_valid = 1'b0; cmd_rd_en = 1'b0; cmd_wr_en = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_idle(input bit toggle, output int lat);
        lat = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                lat = cyc - c0 + 1;
                break;
            end
            @(posedge clk); #2;
            if (toggle) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int lat;
        send_cmd(1'b0, 1'b1, a, d, '0, '0);
        wait_idle(1'b0, lat);
        @(posedge clk); #2;
    endtask

    task automatic chk_beats(input string tag, input int base, input int n,
                             input logic [OUT_W-1:0] first);
        chk({tag, "_count"}, 64'(q_data.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < q_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), 64'(q_data[base+i]), 64'(first + OUT_W'(i)));
                chk($sformatf("%s_last%0d", tag, i), 64'(q_last[base+i]), 64'(i == n - 1));
            end
        end
    endtask

    initial begin
        int lat, base, w0, e0;

        // reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_wen", 64'(ram_wen), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_din", 64'(ram_din), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #2; rstn = 1'b1;
        @(posedge clk); #2;

        // write 0xBEEF to address 5
        send_cmd(1'b0, 1'b1, 14'd5, 16'hBEEF, '0, '0);
        @(negedge clk);
        chk("wr_ram_en", 64'(ram_en), 64'd1);
        chk("wr_ram_wen", 64'(ram_wen), 64'd1);
        chk("wr_ram_addr", 64'(ram_addr), 64'd5);
        chk("wr_ram_din", 64'(ram_din), 64'hBEEF);
        chk("wr_busy", 64'(in_ready), 64'd0);
        wait_idle(1'b0, lat);
        chk("wr_period", 64'(lat), 64'd2);
        @(posedge clk); #2;

        // single-word burst 5..5
        base = q_data.size();
        send_cmd(1'b1, 1'b0, '0, '0, 14'd5, 14'd5);
        @(negedge clk);
        chk("one_busy", 64'(in_ready), 64'd0);
        wait_idle(1'b0, lat);
        chk("one_lat", 64'(lat), 64'd4);
        chk_beats("one", base, 1, 32'h0000BEEF);
        @(posedge clk); #2;

        // fill 10..17, full-rate burst
        w0 = wen_cnt;
        for (int a = 10; a <= 17; a++) write_word(14'(a), 16'(16'h1000 + a));
        chk("fill_wen", 64'(wen_cnt - w0), 64'd8);
        base = q_data.size();
        send_cmd(1'b1, 1'b0, '0, '0, 14'd10, 14'd17);
        wait_idle(1'b0, lat);
        chk("burst_lat", 64'(lat), 64'd11);
        chk_beats("burst", base, 8, 32'h0000100A);
        chk("burst_outstanding", 64'(max_out <= DEPTH), 64'd1);
        @(posedge clk); #2;

        // same burst with random backpressure
        base = q_data.size();
        send_cmd(1'b1, 1'b0, '0, '0, 14'd10, 14'd17);
        out_ready = 1'b0;
        wait_idle(1'b1, lat);
        chk("bp_done", 64'(lat > 0), 64'd1);
        chk_beats("bp", base, 8, 32'h0000100A);
        chk("bp_outstanding", 64'(max_out <= DEPTH), 64'd1);
        @(posedge clk); #2;

        // wrap burst 0x3FFE..0x0001
        write_word(14'h3FFE, 16'h2000);
        write_word(14'h3FFF, 16'h2001);
        write_word(14'h0000, 16'h2002);
        write_word(14'h0001, 16'h2003);
        base = q_data.size();
        send_cmd(1'b1, 1'b0, '0, '0, 14'h3FFE, 14'h0001);
        wait_idle(1'b0, lat);
        chk("wrap_lat", 64'(lat), 64'd7);
        chk_beats("wrap", base, 4, 32'h00002000);
        @(posedge clk); #2;

        // read and write flags together: read wins, no RAM write
        w0 = wen_cnt;
        base = q_data.size();
        send_cmd(1'b1, 1'b1, 14'd20, 16'h5555, 14'd10, 14'd11);
        wait_idle(1'b0, lat);
        chk("both_no_write", 64'(wen_cnt - w0), 64'd0);
        chk("both_mem20", 64'(mem[20]), 64'd0);
        chk_beats("both", base, 2, 32'h0000100A);
        @(posedge clk); #2;

        // no-op command
        e0 = en_cnt;
        send_cmd(1'b0, 1'b0, 14'd7, 16'h7777, 14'd1, 14'd2);
        @(negedge clk);
        chk("noop_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("noop_no_strobe", 64'(en_cnt - e0), 64'd0);
        @(posedge clk); #2;

        // reset after 3 of 8 beats
        base = q_data.size();
        send_cmd(1'b1, 1'b0, '0, '0, 14'd10, 14'd17);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (q_data.size() - base >= 3) break;
        end
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_ram_en", 64'(ram_en), 64'd0);
        chk("mid_rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_last", 64'(out_last), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #2; rstn = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("mid_rst_no_stale", 64'(q_data.size() - base), 64'd3);
        write_word(14'd30, 16'h1234);
        base = q_data.size();
        send_cmd(1'b1, 1'b0, '0, '0, 14'd30, 14'd30);
        wait_idle(1'b0, lat);
        chk("post_rst_lat", 64'(lat), 64'd4);
        chk_beats("post_rst", base, 1, 32'h00001234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sam_mem_ctrl.md
# sam_mem_ctrl

Sequencing controller between the instruction decoder and the 16-bit single-port sample RAM. Accepts one decoded command per handshake and either performs a single-word write or streams a multi-word read burst (start..end address, inclusive) to the output stream with full backpressure. Deasserts `in_ready` while a command is executing and drives `out_last` on the final word of each burst.

## Interface
- `ADDR_W`, 14, RAM address width
- `DATA_W`, 16, RAM word width
- `OUT_W`, 32, output stream width; RAM word zero-extended, `OUT_W >= DATA_W`
- `FIFO_DEPTH`, 4, output buffer entries; min 2, ≥3 for full-rate bursts
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decoded command valid
- `in_ready`  out  1  controller idle, command accepted when `in_valid && in_ready`
- `in_last`  in  1  ignored; every command is single-beat
- `cmd_wr_en`, `cmd_rd_en`, `cmd_go`  in  1 each  decoded command flags; `cmd_go` reserved, ignored
- `cmd_wr_addr`  in  ADDR_W  write address
- `cmd_wr_data`  in  DATA_W  write data
- `cmd_rd_start`, `cmd_rd_end`  in  ADDR_W each  burst bounds, inclusive
- `ram_addr`  out  ADDR_W  RAM address
- `ram_din`  out  DATA_W  RAM write data
- `ram_en`  out  1  RAM access strobe
- `ram_wen`  out  1  RAM write enable (valid with `ram_en`)
- `ram_dout`  in  DATA_W  RAM read data, valid the cycle after a read strobe
- `out_data`  out  OUT_W  stream data
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  downstream ready
- `out_last`  out  1  final word of burst

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: `in_ready`=1. On accept, latch command: `cmd_rd_en`=1 → READ (write flags ignored); else `cmd_wr_en`=1 → WRITE; else no-op, stay IDLE.
- WRITE (one cycle): `ram_en`=1, `ram_wen`=1, `ram_addr`=latched wr_addr, `ram_din`=latched data → IDLE.
- READ: address counter starts at `cmd_rd_start`, increments mod 2^ADDR_W. Read issued (`ram_en`=1, `ram_wen`=0) in a cycle iff `count + pend < FIFO_DEPTH`, where `count` = FIFO occupancy at cycle start, `pend` = 1 if read issued previous cycle. Issue of address == latched end → DRAIN.
- Burst length = ((end − start) mod 2^ADDR_W) + 1; end < start wraps through 0; start == end → one word.
- Each read word pushed into FIFO the cycle after issue, tagged last if its address was the end address.
- DRAIN: no issues; → IDLE when FIFO empty and `pend`=0 (last word popped).
- Output: FIFO head drives `out_data` (zero-extended), `out_valid`=FIFO non-empty, `out_last`=head tag. Pop on `out_valid && out_ready`. Data/last stable while `out_valid && !out_ready`.
- `ram_en`=0 in all cycles not listed above; `ram_addr`/`ram_din` hold last value.
- Reset (any time, incl. mid-burst): state IDLE, FIFO flushed, counters cleared; abandoned burst emits no further words and no `out_last`.
- Reset values: `in_ready`=1 (combinational from IDLE), `ram_en`=0, `ram_wen`=0, `ram_addr`=0, `ram_din`=0, `out_valid`=0, `out_last`=0, `out_data`=0.

## Timing
- Accept at edge E0. WRITE: RAM write strobe in cycle after E0; `in_ready` high again next cycle (2-cycle command period).
- READ: first issue in cycle after E0; data on `ram_dout` next cycle; first `out_valid` in third cycle after E0.
- With `out_ready`=1 and FIFO_DEPTH ≥3: one word per cycle sustained; N-word burst: `in_ready` returns 1 cycle after last pop, i.e. N+3 cycles after E0.
- `out_ready` low: issues stop once `count + pend` reaches FIFO_DEPTH; no word lost or duplicated; resume next cycle after a pop.
- Pop and push in same cycle: occupancy unchanged.
- `in_valid` while busy: held off by `in_ready`=0, no effect.

## Test plan
- Write 0xBEEF to addr 5, then burst start=5 end=5 → one beat `out_data`=0x0000BEEF, `out_last`=1; `in_ready` low from accept+1 until after pop.
- Write addrs 10..17 with 0x1000+addr, burst 10..17, `out_ready`=1 → 8 consecutive beats 0x100A..0x1011, `out_last` only on 0x1011, `in_ready` back 11 cycles after accept.
- Same burst, `out_ready` toggled 1/0 pseudo-randomly → identical 8-word sequence, `ram_en` pulses never exceed FIFO_DEPTH beyond pops.
- Wrap burst start=0x3FFE end=0x0001 → 4 beats from 0x3FFE,0x3FFF,0x0000,0x0001, last on 0x0001.
- Command with `cmd_rd_en`=1 and `cmd_wr_en`=1 → burst performed, no RAM write (`ram_wen` never 1); no-op command (all flags 0) → no RAM strobe, `in_ready` stays 1.
- `rstn` low mid-burst (after 3 of 8 beats) → all outputs at reset values immediately; after release, no stale beats, new write/read commands execute normally.
